// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame sizing,
// used by both the receive and transmit paths.
package uart_pkg;

  localparam int UART_DEF_CLKS_PER_BIT = 16;
  localparam int UART_DEF_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchronizer for a single asynchronous input. RST_VAL sets the
// value both flops take in reset, which should match the line's idle level.
module uart_bit_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-edge detect, mid-bit sampling with a clock-divider
// counter, optional parity, and one-cycle result pulses issued one cycle
// after the stop-bit sample.
//
//   state  | meaning
//   IDLE   | waiting for a falling edge on the synchronized line
//   START  | half a bit into the start bit, confirm it is still low
//   DATA   | sample DATA_BITS data bits at mid-bit, LSB first
//   PARITY | sample the parity bit and latch a mismatch
//   STOP   | sample the stop bit, then hand the decision to the output stage
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DEF_DATA_BITS,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  uart_rx_state_t       state;
  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_s;
  logic                 rx_prev;
  logic                 fall;
  logic                 par_err;
  logic                 stop_hit;
  logic                 stop_bit;

  uart_bit_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_serial),
    .q   (rx_s)
  );

  assign fall    = rx_prev & ~rx_s;
  assign rx_busy = (state != IDLE);

  // Previous synchronized line value for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_prev <= 1'b1;
    else     rx_prev <= rx_s;
  end

  // Frame sequencing: bit timing, data shift, parity latch, stop sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_err  <= 1'b0;
      stop_hit <= 1'b0;
      stop_bit <= 1'b1;
    end else begin
      stop_hit <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state   <= START;
            clk_cnt <= '0;
          end
        end
        START: begin
          if (clk_cnt == HALF_M1) begin
            clk_cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
              par_err <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == FULL_M1) begin
            clk_cnt <= '0;
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) state <= (PARITY_EN != 0) ? PARITY : STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (clk_cnt == FULL_M1) begin
            clk_cnt <= '0;
            par_err <= ((^shreg) ^ rx_s) != (PARITY_ODD != 0);
            state   <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt == FULL_M1) begin
            clk_cnt  <= '0;
            stop_hit <= 1'b1;
            stop_bit <= rx_s;
            // Leaving at mid stop bit gives half a bit to catch the next start.
            state    <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result stage: one-cycle pulses and data load from the stop decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      if (stop_hit) begin
        if (stop_bit && !par_err) begin
          rx_valid <= 1'b1;
          rx_data  <= shreg;
        end
        if (!stop_bit) rx_frame_err  <= 1'b1;
        if (par_err)   rx_parity_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 instance and an even-parity instance, each fed
// from its own serial line. Expected events come from a frame-level model.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       line_a = 1'b1;
  logic       line_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic       valid_a, ferr_a, perr_a, busy_a;
  logic       valid_b, ferr_b, perr_b, busy_b;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst(rst), .rx_serial(line_a), .rx_data(data_a), .rx_valid(valid_a),
    .rx_frame_err(ferr_a), .rx_parity_err(perr_a), .rx_busy(busy_a)
  );

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .clk(clk), .rst(rst), .rx_serial(line_b), .rx_data(data_b), .rx_valid(valid_b),
    .rx_frame_err(ferr_b), .rx_parity_err(perr_b), .rx_busy(busy_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;   // 0 valid, 1 frame error, 2 parity error
    int data;
    int cyc;
  } ev_t;

  ev_t act_a[$], act_b[$], exp_a[$], exp_b[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  dbl_cnt  = 0;
  int  excl_cnt = 0;
  int  last_a   = 0;
  int  last_b   = 0;
  logic pva = 0, pfa = 0, ppa = 0, pvb = 0, pfb = 0, ppb = 0;

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, want, want);
    end
  endtask

  // Record every output pulse with its cycle; track pulse width and exclusivity.
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      e.cyc = cyc;
      if (valid_a) begin e.kind = 0; e.data = int'(data_a); act_a.push_back(e); end
      if (ferr_a)  begin e.kind = 1; e.data = 0; act_a.push_back(e); end
      if (perr_a)  begin e.kind = 2; e.data = 0; act_a.push_back(e); end
      if (valid_b) begin e.kind = 0; e.data = int'(data_b); act_b.push_back(e); end
      if (ferr_b)  begin e.kind = 1; e.data = 0; act_b.push_back(e); end
      if (perr_b)  begin e.kind = 2; e.data = 0; act_b.push_back(e); end
      if ((valid_a && pva) || (ferr_a && pfa) || (perr_a && ppa) ||
          (valid_b && pvb) || (ferr_b && pfb) || (perr_b && ppb)) dbl_cnt++;
      if ((valid_a && ferr_a) || (valid_b && ferr_b)) excl_cnt++;
    end
    pva <= valid_a; pfa <= ferr_a; ppa <= perr_a;
    pvb <= valid_b; pfb <= ferr_b; ppb <= perr_b;
  end

  task automatic drive_bits(input bit sel, input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel) line_b = bits[i];
      else     line_a = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  // Send one frame and append the model's expected events.
  // Pulse lands LAT posedges after the first posedge that sees the falling line.
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit stop, input bit bad);
    logic [11:0] f;
    bit          p;
    int          lat;
    ev_t         e;
    p   = (^d) ^ bad;
    lat = 2 + CPB / 2 + (8 + int'(sel) + 1) * CPB + 1;
    e.cyc = cyc + 1 + lat;
    if (sel) f = {1'b1, stop, p, d, 1'b0};
    else     f = {2'b11, stop, d, 1'b0};
    if (stop && !bad) begin
      e.kind = 0; e.data = int'(d);
      if (sel) begin exp_b.push_back(e); last_b = int'(d); end
      else     begin exp_a.push_back(e); last_a = int'(d); end
    end
    if (!stop) begin
      e.kind = 1; e.data = 0;
      if (sel) exp_b.push_back(e); else exp_a.push_back(e);
    end
    if (bad) begin
      e.kind = 2; e.data = 0;
      if (sel) exp_b.push_back(e); else exp_a.push_back(e);
    end
    drive_bits(sel, f, sel ? 11 : 10);
  endtask

  task automatic drain();
    line_a = 1'b1;
    line_b = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("a_count", act_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < act_a.size(); i++) begin
      check("a_kind", act_a[i].kind, exp_a[i].kind);
      check("a_data", act_a[i].data, exp_a[i].data);
      check("a_cycle", act_a[i].cyc, exp_a[i].cyc);
    end
    check("b_count", act_b.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < act_b.size(); i++) begin
      check("b_kind", act_b[i].kind, exp_b[i].kind);
      check("b_data", act_b[i].data, exp_b[i].data);
      check("b_cycle", act_b[i].cyc, exp_b[i].cyc);
    end
    check("a_hold", int'(data_a), last_a);
    check("b_hold", int'(data_b), last_b);
    check("a_idle", int'(busy_a), 0);
    check("b_idle", int'(busy_b), 0);
    act_a.delete(); act_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  initial begin
    logic [7:0] d;
    int         busy_seen;
    bit         prev_stop;
    bit         stop;
    bit         bad;
    int         gap;

    repeat (3) @(negedge clk);
    check("rst_data", int'(data_a), 0);
    check("rst_valid", int'(valid_a), 0);
    check("rst_ferr", int'(ferr_a), 0);
    check("rst_perr", int'(perr_a), 0);
    check("rst_busy", int'(busy_a | busy_b), 0);
    rst = 1'b0;
    repeat (4 * CPB) @(negedge clk);

    send_frame(0, 8'hA5, 1, 0);
    drain();

    send_frame(0, 8'h00, 1, 0);
    send_frame(0, 8'hFF, 1, 0);
    repeat (CPB) @(negedge clk);
    check("b2b_gap", (act_a.size() >= 2) ? act_a[1].cyc - act_a[0].cyc : -1, 10 * CPB);
    drain();

    send_frame(0, 8'h3C, 0, 0);
    repeat (50 * CPB) @(negedge clk);
    drain();

    busy_seen = 0;
    line_a = 1'b0;
    repeat (4) @(negedge clk);
    line_a = 1'b1;
    repeat (20) begin
      @(negedge clk);
      busy_seen = busy_seen | int'(busy_a);
    end
    check("glitch_busy", busy_seen, 1);
    drain();

    send_frame(1, 8'h07, 1, 0);
    send_frame(1, 8'h07, 1, 1);
    drain();

    d = 8'h5A;
    drive_bits(0, {2'b11, 1'b1, d, 1'b0}, 4);
    line_a = d[3];
    repeat (CPB / 2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_data", int'(data_a), 0);
    check("arst_flags", int'({valid_a, ferr_a, perr_a}), 0);
    check("arst_busy", int'(busy_a), 0);
    check("arst_data_b", int'(data_b), 0);
    @(negedge clk);
    rst = 1'b0;
    line_a = 1'b1;
    last_a = 0;
    last_b = 0;
    repeat (2 * CPB) @(negedge clk);
    send_frame(0, 8'h81, 1, 0);
    drain();

    prev_stop = 1;
    for (int i = 0; i < 20; i++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 7) != 0);
      gap  = $urandom_range(0, 2);
      if (!prev_stop && gap == 0) gap = 1;
      line_a = 1'b1;
      repeat (gap * CPB) @(negedge clk);
      send_frame(0, d, stop, 0);
      prev_stop = stop;
    end
    drain();

    prev_stop = 1;
    for (int i = 0; i < 15; i++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 5) != 0);
      bad  = ($urandom_range(0, 3) == 0);
      gap  = $urandom_range(0, 2);
      if (!prev_stop && gap == 0) gap = 1;
      line_b = 1'b1;
      repeat (gap * CPB) @(negedge clk);
      send_frame(1, d, stop, bad);
      prev_stop = stop;
    end
    drain();

    check("pulse_width", dbl_cnt, 0);
    check("valid_ferr_excl", excl_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
